// File: rtl/fft_pkg.sv
// Shared FFT datapath types and constants.
// Phase encodings, default word width and a log2 helper.
package fft_pkg;

  localparam int DATA_WIDTH = 25;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } phase_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_delay_commutator_line.sv
// D-deep shift register feeding the SDF butterfly.
// Ports: clock, resetn/clear (sync zero), enable, sel_fb, write_data, fb_data -> head.
module sdf_delay_commutator_line
  import fft_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int delay_depth = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  sel_fb,
  input  logic [data_width-1:0] write_data,
  input  logic [data_width-1:0] fb_data,
  output logic [data_width-1:0] head
);

  logic [data_width-1:0] dl_q [delay_depth];
  logic [data_width-1:0] dl_d [delay_depth];

  always_comb begin
    for (int i = 0; i < delay_depth; i++) begin
      dl_d[i] = dl_q[i];
    end
    if (resetn || clear) begin
      for (int i = 0; i < delay_depth; i++) begin
        dl_d[i] = '0;
      end
    end else if (enable) begin
      for (int i = delay_depth - 1; i > 0; i--) begin
        dl_d[i] = dl_q[i-1];
      end
      dl_d[0] = sel_fb ? fb_data : write_data;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < delay_depth; i++) begin
      dl_q[i] <= dl_d[i];
    end
  end

  assign head = dl_q[delay_depth-1];

endmodule

// File: rtl/sdf_delay_commutator.sv
// Radix-2 SDF delay/commutator: buffers half a block, pairs it with live input.
// Ports: clock, resetn, enable, clear, write_data, fb_data -> bf_*, drain_*, phase.
module sdf_delay_commutator
  import fft_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int delay_depth = 8,
  parameter int cnt_width   = clog2(delay_depth)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [data_width-1:0] write_data,
  input  logic [data_width-1:0] fb_data,
  output logic [data_width-1:0] bf_a,
  output logic [data_width-1:0] bf_b,
  output logic                  bf_valid,
  output logic [data_width-1:0] drain_data,
  output logic                  drain_valid,
  output logic                  phase
);

  localparam logic [cnt_width-1:0] CNT_LAST =
    cnt_width'(delay_depth - 1);

  logic [cnt_width-1:0]  cnt_q, cnt_d;
  phase_e                phase_q, phase_d;
  logic                  primed_q, primed_d;
  logic [data_width-1:0] drain_data_q, drain_data_d;
  logic                  drain_valid_q, drain_valid_d;
  logic [data_width-1:0] head;

  sdf_delay_commutator_line #(
    .data_width (data_width),
    .delay_depth(delay_depth)
  ) u_line (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (clear),
    .enable    (enable),
    .sel_fb    (phase_q == PAIR),
    .write_data(write_data),
    .fb_data   (fb_data),
    .head      (head)
  );

  always_comb begin
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    primed_d      = primed_q;
    drain_data_d  = drain_data_q;
    drain_valid_d = 1'b0;
    if (resetn || clear) begin
      cnt_d        = '0;
      phase_d      = FILL;
      primed_d     = 1'b0;
      drain_data_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + cnt_width'(1);
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == FILL) ? PAIR : FILL;
        // Drain data is only meaningful after one full PAIR pass.
        if (phase_q == PAIR) primed_d = 1'b1;
      end
      if (phase_q == FILL) begin
        drain_data_d  = head;
        drain_valid_d = primed_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    cnt_q         <= cnt_d;
    phase_q       <= phase_d;
    primed_q      <= primed_d;
    drain_data_q  <= drain_data_d;
    drain_valid_q <= drain_valid_d;
  end

  assign bf_a        = head;
  assign bf_b        = write_data;
  assign bf_valid    = enable & (phase_q == PAIR);
  assign drain_data  = drain_data_q;
  assign drain_valid = drain_valid_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_sdf_delay_commutator.sv
// Directed bench for sdf_delay_commutator at D=4.
// Table-driven streaming vectors plus hand-written corner sequences.
module tb_sdf_delay_commutator;

  localparam int W = 25;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] write_data = '0;
  logic [W-1:0] fb_data = '0;
  logic [W-1:0] bf_a, bf_b, drain_data;
  logic         bf_valid, drain_valid, phase;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int wd;
    int fb;
    int bfv;
    int bfa;
    int dv;
    int dd;
    int ph;
  } vec_t;

  vec_t vecs [16];

  sdf_delay_commutator #(
    .data_width (W),
    .delay_depth(D),
    .cnt_width  (2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .clear      (clear),
    .write_data (write_data),
    .fb_data    (fb_data),
    .bf_a       (bf_a),
    .bf_b       (bf_b),
    .bf_valid   (bf_valid),
    .drain_data (drain_data),
    .drain_valid(drain_valid),
    .phase      (phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic cl, input logic rs,
                       input int wd, input int fb);
    @(negedge clock);
    enable     = en;
    clear      = cl;
    resetn     = rs;
    write_data = W'(wd);
    fb_data    = W'(fb);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_stream(input int gap, input string tag);
    do_reset();
    for (int s = 0; s < 16; s++) begin
      drive(1'b1, 1'b0, 1'b0, vecs[s].wd, vecs[s].fb);
      chk({tag, " bf_valid"}, int'(bf_valid), vecs[s].bfv);
      chk({tag, " bf_a"}, int'(bf_a), vecs[s].bfa);
      chk({tag, " bf_b"}, int'(bf_b), vecs[s].wd);
      tick();
      chk({tag, " drain_valid"}, int'(drain_valid), vecs[s].dv);
      chk({tag, " drain_data"}, int'(drain_data), vecs[s].dd);
      chk({tag, " phase"}, int'(phase), vecs[s].ph);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, 1'b0, 555, 666);
        chk({tag, " gap bf_valid"}, int'(bf_valid), 0);
        tick();
        chk({tag, " gap drain_valid"}, int'(drain_valid), 0);
        chk({tag, " gap drain_data"}, int'(drain_data), vecs[s].dd);
        chk({tag, " gap phase"}, int'(phase), vecs[s].ph);
      end
    end
  endtask

  initial begin
    int dv_cnt;
    int wd;

    // Strobe s (1..16): 1-4 FILL, 5-8 PAIR, 9-12 FILL (primed), 13-16 PAIR.
    for (int i = 0; i < 16; i++) begin
      int s;
      s = i + 1;
      vecs[i].wd  = s;
      vecs[i].fb  = 100 + s;
      vecs[i].bfv = ((s >= 5 && s <= 8) || s >= 13) ? 1 : 0;
      vecs[i].bfa = (s <= 4) ? 0 : (s <= 8) ? s - 4 :
                    (s <= 12) ? s + 96 : s - 4;
      vecs[i].dv  = (s >= 9 && s <= 12) ? 1 : 0;
      vecs[i].dd  = (s <= 8) ? 0 : (s <= 12) ? s + 96 : 108;
      vecs[i].ph  = (s <= 3) ? 0 : (s <= 7) ? 1 : (s <= 11) ? 0 :
                    (s <= 15) ? 1 : 0;
    end

    // Reset held 2 cycles with enable and random data.
    drive(1'b1, 1'b0, 1'b1, int'($urandom_range(1, 1000)), 7);
    tick();
    drive(1'b1, 1'b0, 1'b1, int'($urandom_range(1, 1000)), 9);
    tick();
    chk("rst phase", int'(phase), 0);
    chk("rst drain_data", int'(drain_data), 0);
    chk("rst drain_valid", int'(drain_valid), 0);
    chk("rst bf_a", int'(bf_a), 0);
    chk("rst bf_valid", int'(bf_valid), 0);

    run_stream(0, "stream");
    run_stream(3, "gaps");

    // Clear at strobe 6 (mid-PAIR).
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      drive(1'b1, 1'b0, 1'b0, s, 100 + s);
      tick();
    end
    chk("clr pre phase", int'(phase), 1);
    drive(1'b1, 1'b1, 1'b0, 6, 106);
    tick();
    chk("clr phase", int'(phase), 0);
    chk("clr bf_a", int'(bf_a), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 50 + k, 0);
      chk("clr fill bf_a", int'(bf_a), 0);
      tick();
      chk("clr drain_valid", int'(drain_valid), 0);
      chk("clr drain_data", int'(drain_data), 0);
    end
    chk("clr phase after", int'(phase), 1);
    drive(1'b1, 1'b0, 1'b0, 60, 0);
    chk("clr pair bf_a", int'(bf_a), 50);

    // Priority: reset beats clear and enable, counter restarts.
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      drive(1'b1, 1'b0, 1'b0, 10 + s, 0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 77, 0);
    tick();
    chk("prio rst phase", int'(phase), 0);
    chk("prio rst bf_a", int'(bf_a), 0);
    for (int s = 1; s <= 3; s++) begin
      drive(1'b1, 1'b0, 1'b0, 20 + s, 0);
      tick();
      chk("prio cnt phase", int'(phase), 0);
    end
    // Clear with enable: 99 must not enter the line.
    drive(1'b1, 1'b1, 1'b0, 99, 99);
    tick();
    chk("prio clr phase", int'(phase), 0);
    for (int s = 1; s <= 4; s++) begin
      drive(1'b1, 1'b0, 1'b0, s, 0);
      tick();
    end
    chk("prio clr toggle", int'(phase), 1);
    drive(1'b1, 1'b0, 1'b0, 40, 0);
    chk("prio clr bf_a", int'(bf_a), 1);

    // Wrap-around: 48 strobes.
    do_reset();
    dv_cnt = 0;
    for (int s = 1; s <= 48; s++) begin
      wd = int'($urandom_range(0, 4095));
      drive(1'b1, 1'b0, 1'b0, wd, wd + 1);
      tick();
      chk("wrap phase", int'(phase), (s / 4) % 2);
      if (drain_valid) dv_cnt++;
      if (s == 8) chk("wrap unprimed s8", int'(drain_valid), 0);
      if (s == 9) chk("wrap primed s9", int'(drain_valid), 1);
    end
    chk("wrap dv count", dv_cnt, 20);

    drive(1'b0, 1'b0, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdf_delay_commutator.md
Name: sdf_delay_commutator

Overview:
- Radix-2 single-path delay-feedback (SDF) delay/commutator stage for the WISHBONE_FFT datapath.
- Buffers the first half of each block in a depth-D delay line. It then presents the (x[n], x[n+D]) pair combinationally to the butterfly adder.
- The butterfly sum is captured downstream by the shiftreg1 pipeline register.
- The butterfly difference is fed back into the delay line and drained out in the next fill phase.

Parameters:
- data_width, 25, width of one packed sample word (same width as the downstream shiftreg1).
- delay_depth, 8, delay-line length D; must be a power of two, at least 2.
- cnt_width, 3, log2(delay_depth); width of the sample counter.

Ports:
- clock, in, 1, single rising-edge clock.
- resetn, in, 1, reset: synchronous, active-high despite the name; 1 = reset on next clock edge.
- enable, in, 1, sample strobe; each cycle with enable=1 consumes one write_data and one fb_data.
- clear, in, 1, synchronous block restart; acts regardless of enable.
- write_data, in, data_width, incoming sample.
- fb_data, in, data_width, butterfly difference for the pair currently on bf_a/bf_b (same cycle, combinational return path).
- bf_a, out, data_width, combinational: delay-line head dl[D-1].
- bf_b, out, data_width, combinational: write_data passthrough.
- bf_valid, out, 1, combinational: enable & phase.
- drain_data, out, data_width, registered: delay-line head shifted out during FILL.
- drain_valid, out, 1, registered: one-cycle pulse qualifying drain_data.
- phase, out, 1, registered: 0 = FILL, 1 = PAIR.

Behaviour:
- State:
  - delay line dl[0..D-1];
  - cnt (cnt_width bits);
  - phase;
  - primed flag, set once the first PAIR phase completes.
- Priority each edge: resetn > clear > enable.
- resetn=1 or clear=1 (both identical):
  - dl all zero, cnt=0, phase=0, primed=0;
  - drain_data=0, drain_valid=0;
  - no shift occurs even if enable=1.
- enable=1, phase=0 (FILL):
  - dl shifts one place toward the head; dl[0] <= write_data.
  - drain_data <= old dl[D-1]; drain_valid <= primed.
- enable=1, phase=1 (PAIR):
  - bf_a = dl[D-1], bf_b = write_data, bf_valid = 1, all combinational in the same cycle.
  - dl shifts; dl[0] <= fb_data.
  - drain_valid <= 0; drain_data holds.
- Counter, on every enable=1 edge:
  - cnt increments.
  - At cnt == D-1: cnt wraps to 0 and phase toggles.
  - On the PAIR->FILL toggle, primed <= 1; it stays 1 until reset/clear.
- enable=0:
  - dl, cnt, phase, primed and drain_data hold; drain_valid <= 0.
  - bf_valid = 0; bf_a/bf_b still reflect dl[D-1] and write_data.
- Latency:
  - pair output: 0 cycles (combinational);
  - drain output: 1 clock after the consuming strobe;
  - fb value entering the line reappears on drain_data exactly D strobes later.
- Width: no arithmetic in this block; words are stored bit-exact with no growth or truncation.
- Clear or reset mid-PAIR: partial block discarded. The next D strobes are FILL with drain_valid=0, because primed=0.

Decomposition:
- Shared package (fft_pkg): data_width default; FILL/PAIR phase encodings; log2 constant function for cnt_width.
- One natural sub-module: sdf_delay_line, a D-deep shift register with enable, clear and a 2:1 input mux (write_data/fb_data selected by phase).
- Counter, phase and primed logic stay in the top level.

Test Plan:
- Reset: assert resetn for 2 cycles with enable=1 and random data -> phase=0, drain_data=0, drain_valid=0, bf_a=0, bf_valid=0.
- Streaming, D=4: samples 1..16 on consecutive strobes, fb_data=100+sample.
  - Strobes 5-8 -> bf_a=1,2,3,4, bf_b=5,6,7,8, bf_valid=1.
  - Strobes 9-12 -> drain_data=105,106,107,108 one clock later, drain_valid=1.
  - Strobes 13-16 -> bf_a=9,10,11,12.
- Enable gaps: repeat the streaming test with enable=0 for 3 cycles between strobes -> identical bf/drain sequences; drain_valid never high on a gap+1 cycle without a preceding strobe.
- Clear mid-PAIR: clear at strobe 6 -> phase=0, dl zeroed; next 4 strobes give drain_valid=0 and drain_data=0.
- Priority: resetn=1 with clear=1 and enable=1 -> no shift, cnt=0; then clear=1 with enable=1 -> write_data is not loaded.
- Wrap-around: 48 strobes, D=4 -> phase toggles exactly every 4 strobes; primed rises after strobe 8; drain_valid asserted on 20 strobes total.
